// File: rtl/fp_mult_result_collector.sv
// rtl/fp_mult_result_collector.sv - periodic FP32 multiplier result sampler with show-ahead FIFO, sticky flags, drop counter
// Optional flag-combination checker enabled by FLAG_COMBO_CHECK_EN.
module fp_mult_result_collector #(
   parameter int SAMPLE_PERIOD = 4,
   parameter int FIFO_DEPTH    = 8,
   parameter int DROP_CNT_W    = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [31:0]                   z,
   input  logic [0:7]                    status,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [31:0]                   out_z,
   output logic [0:7]                    out_status,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [0:7]                    sticky,
   input  logic                          sticky_clr,
   output logic [DROP_CNT_W-1:0]         drop_cnt
`ifdef FLAG_COMBO_CHECK_EN
   ,
   output logic                          combo_err,
   output logic [7:0]                    combo_err_cnt
`endif
);

   localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [PW-1:0] PHASE_LAST = PW'(SAMPLE_PERIOD - 1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);
   localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

   logic [PW-1:0] phase;
   logic          sample_event;

   logic [31:0]   z_mem  [FIFO_DEPTH];
   logic [0:7]    st_mem [FIFO_DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [CW-1:0] count;
   logic          full;
   logic          push;
   logic          pop;
   logic          drop;

   // Sample on the last phase of each period so the first sample lands SAMPLE_PERIOD edges after reset.
   assign sample_event = (phase == PHASE_LAST);

   // Free-running phase counter that wraps at the result cadence.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase <= '0;
      end else if (sample_event) begin
         phase <= '0;
      end else begin
         phase <= phase + 1'b1;
      end
   end

   // A full FIFO still accepts a sample when the head leaves on the same edge.
   assign full = (count == COUNT_FULL);
   assign pop  = out_valid && out_ready;
   assign push = sample_event && (!full || pop);
   assign drop = sample_event && full && !pop;

   // Storage is written only on push; contents need no reset because reads are gated by occupancy.
   always_ff @(posedge clk) begin
      if (push) begin
         z_mem[wptr]  <= z;
         st_mem[wptr] <= status;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally since the depth is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Show-ahead head; forced to zero when empty so reset and idle present clean outputs.
   always_comb begin
      out_valid  = (count != '0);
      out_z      = 32'd0;
      out_status = '0;
      if (out_valid) begin
         out_z      = z_mem[rptr];
         out_status = st_mem[rptr];
      end
   end

   assign fifo_count = count;

   // Saturating count of samples lost because the FIFO was full and not draining.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (drop && (drop_cnt != DROP_MAX)) begin
         drop_cnt <= drop_cnt + 1'b1;
      end
   end

   // Sticky flags accumulate every sampled status, dropped or not; a clear keeps only the concurrent sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky <= '0;
      end else if (sticky_clr) begin
         sticky <= sample_event ? status : '0;
      end else if (sample_event) begin
         sticky <= sticky | status;
      end
   end

`ifdef FLAG_COMBO_CHECK_EN
   logic f_zero, f_inf, f_nan, f_tiny, f_huge, f_inexact, f_ovf, f_unf;
   logic illegal;

   // Flag pairs that a correct multiplier can never report together.
   always_comb begin
      f_zero    = status[0];
      f_inf     = status[1];
      f_nan     = status[2];
      f_tiny    = status[3];
      f_huge    = status[4];
      f_inexact = status[5];
      f_ovf     = status[6];
      f_unf     = status[7];
      illegal   = (f_zero & (f_inf | f_nan | f_tiny | f_huge))
                | (f_inf & f_tiny)
                | (f_nan & (f_tiny | f_huge | f_inexact | f_ovf | f_unf))
                | (f_tiny & (f_huge | f_ovf))
                | (f_huge & f_unf)
                | (f_ovf & f_unf);
   end

   // One-cycle error pulse and saturating error count for each offending sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         combo_err     <= 1'b0;
         combo_err_cnt <= 8'd0;
      end else begin
         combo_err <= sample_event && illegal;
         if (sample_event && illegal && (combo_err_cnt != 8'hFF)) begin
            combo_err_cnt <= combo_err_cnt + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fp_mult_result_collector.sv
// tb/tb_fp_mult_result_collector.sv - directed self-checking bench for fp_mult_result_collector
module tb_fp_mult_result_collector;

   logic        clk;
   logic        rst;
   logic [31:0] z;
   logic [0:7]  status;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_z;
   logic [0:7]  out_status;
   logic [3:0]  fifo_count;
   logic [0:7]  sticky;
   logic        sticky_clr;
   logic [7:0]  drop_cnt;
`ifdef FLAG_COMBO_CHECK_EN
   logic        combo_err;
   logic [7:0]  combo_err_cnt;
`endif

   int n_checks;
   int n_fail;

   fp_mult_result_collector dut (
      .clk(clk),
      .rst(rst),
      .z(z),
      .status(status),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_z(out_z),
      .out_status(out_status),
      .fifo_count(fifo_count),
      .sticky(sticky),
      .sticky_clr(sticky_clr),
      .drop_cnt(drop_cnt)
`ifdef FLAG_COMBO_CHECK_EN
      ,
      .combo_err(combo_err),
      .combo_err_cnt(combo_err_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Leaves the bench 1 time unit after the edge preceding edge 1.
   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      z = 32'h3F80_0000; status = '0; out_ready = 1'b1; sticky_clr = 1'b0;
      rst = 1'b1;
      #2;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
      n_checks++; if (out_z !== 32'd0) begin n_fail++; $display("FAIL reset_z got %h want 0", out_z); end
      n_checks++; if (out_status !== 8'd0) begin n_fail++; $display("FAIL reset_status got %b want 0", out_status); end
      n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", fifo_count); end
      n_checks++; if (sticky !== 8'd0) begin n_fail++; $display("FAIL reset_sticky got %b want 0", sticky); end
      n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
   endtask

   task automatic test_cadence();
      z = 32'h3F80_0000; status = '0; out_ready = 1'b1;
      do_reset();
      for (int e = 1; e <= 12; e++) begin
         tick(1);
         n_checks++;
         if (out_valid !== ((e % 4) == 0)) begin
            n_fail++; $display("FAIL cadence_valid edge %0d got %b want %b", e, out_valid, (e % 4) == 0);
         end
         if ((e % 4) == 0) begin
            n_checks++;
            if (out_z !== 32'h3F80_0000) begin n_fail++; $display("FAIL cadence_z edge %0d got %h want 3f800000", e, out_z); end
         end
      end
   endtask

   task automatic test_overflow_and_back_to_back();
      logic [31:0] exp_z [8];
      out_ready = 1'b0; status = '0;
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         z = 32'h100 + k;
         tick(4);
         if (k == 1 || k == 5) begin
            n_checks++;
            if (out_z !== 32'h101) begin n_fail++; $display("FAIL hold_z sample %0d got %h want 101", k, out_z); end
         end
         if (k == 8) begin
            n_checks++;
            if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL full_count got %0d want 8", fifo_count); end
            n_checks++;
            if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL drop_before got %0d want 0", drop_cnt); end
         end
      end
      n_checks++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL drop_count got %0d want 8", fifo_count); end
      n_checks++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL drop_cnt got %0d want 2", drop_cnt); end
      n_checks++; if (out_z !== 32'h101) begin n_fail++; $display("FAIL drop_head got %h want 101", out_z); end
      // Full FIFO: ready only on the sample edge gives push and pop together.
      z = 32'hAA;
      tick(3);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      n_checks++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL b2b_count got %0d want 8", fifo_count); end
      n_checks++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL b2b_drop got %0d want 2", drop_cnt); end
      for (int i = 0; i < 7; i++) exp_z[i] = 32'h102 + i;
      exp_z[7] = 32'hAA;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (out_z !== exp_z[i]) begin n_fail++; $display("FAIL drain_order %0d got %h want %h", i, out_z, exp_z[i]); end
         tick(1);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_sticky();
      out_ready = 1'b1; sticky_clr = 1'b0; z = 32'h4000_0000;
      do_reset();
      status = 8'b0000_0100;
      tick(4);
      n_checks++; if (sticky !== 8'b0000_0100) begin n_fail++; $display("FAIL sticky_1 got %b want 00000100", sticky); end
      n_checks++; if (out_status !== 8'b0000_0100) begin n_fail++; $display("FAIL head_status got %b want 00000100", out_status); end
      status = 8'b0000_0001;
      tick(4);
      n_checks++; if (sticky !== 8'b0000_0101) begin n_fail++; $display("FAIL sticky_2 got %b want 00000101", sticky); end
      status = 8'b0100_0000;
      tick(3);
      sticky_clr = 1'b1;
      tick(1);
      n_checks++; if (sticky !== 8'b0100_0000) begin n_fail++; $display("FAIL sticky_clr_sample got %b want 01000000", sticky); end
      tick(1);
      sticky_clr = 1'b0;
      n_checks++; if (sticky !== 8'b0000_0000) begin n_fail++; $display("FAIL sticky_clr_idle got %b want 0", sticky); end
      status = '0;
   endtask

   task automatic test_mid_reset();
      out_ready = 1'b0; status = 8'b0000_0100; z = 32'h1234;
      do_reset();
      tick(12);
      n_checks++; if (fifo_count !== 4'd3) begin n_fail++; $display("FAIL pre_reset_count got %0d want 3", fifo_count); end
      tick(2);
      rst = 1'b1;
      #1;
      n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL async_count got %0d want 0", fifo_count); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid got %b want 0", out_valid); end
      n_checks++; if (sticky !== 8'd0) begin n_fail++; $display("FAIL async_sticky got %b want 0", sticky); end
      n_checks++; if (out_z !== 32'd0) begin n_fail++; $display("FAIL async_z got %h want 0", out_z); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         tick(1);
         n_checks++;
         if (fifo_count !== ((e == 4) ? 4'd1 : 4'd0)) begin
            n_fail++; $display("FAIL restart_count edge %0d got %0d want %0d", e, fifo_count, (e == 4) ? 1 : 0);
         end
      end
   endtask

`ifdef FLAG_COMBO_CHECK_EN
   task automatic test_combo();
      out_ready = 1'b0; z = 32'h7FC0_0000;
      do_reset();
      n_checks++; if (combo_err_cnt !== 8'd0) begin n_fail++; $display("FAIL combo_reset_cnt got %0d want 0", combo_err_cnt); end
      status = 8'b1100_0000;
      tick(4);
      n_checks++; if (combo_err !== 1'b1) begin n_fail++; $display("FAIL combo_pulse got %b want 1", combo_err); end
      n_checks++; if (combo_err_cnt !== 8'd1) begin n_fail++; $display("FAIL combo_cnt got %0d want 1", combo_err_cnt); end
      n_checks++; if (fifo_count !== 4'd1) begin n_fail++; $display("FAIL combo_queued got %0d want 1", fifo_count); end
      status = 8'b0000_0110;
      tick(1);
      n_checks++; if (combo_err !== 1'b0) begin n_fail++; $display("FAIL combo_pulse_end got %b want 0", combo_err); end
      tick(3);
      n_checks++; if (combo_err_cnt !== 8'd1) begin n_fail++; $display("FAIL combo_legal_cnt got %0d want 1", combo_err_cnt); end
   endtask
`endif

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_cadence();
      test_overflow_and_back_to_back();
      test_sticky();
      test_mid_reset();
`ifdef FLAG_COMBO_CHECK_EN
      test_combo();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
